// File: rtl/kamacore_pkg.sv
// Shared types and constants for the kamacore load/store path.
package kamacore_pkg;

  localparam int unsigned CPU_WIDTH  = 32;
  localparam int unsigned ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    STORE = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Legal width code for the op kind and naturally aligned for that width.
  function automatic logic lsu_req_ok(input logic we, input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B:  ok = 1'b1;
      F3_H:  ok = ~addr_lo[0];
      F3_W:  ok = (addr_lo == 2'b00);
      F3_BU: ok = ~we;
      F3_HU: ok = ~we & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/kamacore_lsu_align.sv
// Lane steering: sub-word load extraction/extension and store read-modify-write merge.
module kamacore_lsu_align
  import kamacore_pkg::*;
(
  input  logic [2:0]           funct3,
  input  logic [1:0]           addr_lo,
  input  logic [CPU_WIDTH-1:0] word,
  input  logic [CPU_WIDTH-1:0] wdata,
  output logic [CPU_WIDTH-1:0] load_data,
  output logic [CPU_WIDTH-1:0] store_data
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

  logic [BYTE_W-1:0] byte_sel;
  logic [HALF_W-1:0] half_sel;

  always_comb begin
    byte_sel = word[{addr_lo, 3'b000} +: BYTE_W];
    half_sel = addr_lo[1] ? word[CPU_WIDTH-1:HALF_W] : word[HALF_W-1:0];

    load_data = word;
    case (funct3)
      F3_B:  load_data = {{(CPU_WIDTH-BYTE_W){byte_sel[BYTE_W-1]}}, byte_sel};
      F3_BU: load_data = {{(CPU_WIDTH-BYTE_W){1'b0}}, byte_sel};
      F3_H:  load_data = {{(CPU_WIDTH-HALF_W){half_sel[HALF_W-1]}}, half_sel};
      F3_HU: load_data = {{(CPU_WIDTH-HALF_W){1'b0}}, half_sel};
      default: load_data = word;
    endcase

    // Stores keep the untouched lanes of the currently stored word.
    store_data = wdata;
    case (funct3)
      F3_B: begin
        store_data = word;
        store_data[{addr_lo, 3'b000} +: BYTE_W] = wdata[BYTE_W-1:0];
      end
      F3_H: begin
        store_data = word;
        if (addr_lo[1]) store_data[CPU_WIDTH-1:HALF_W] = wdata[HALF_W-1:0];
        else            store_data[HALF_W-1:0]         = wdata[HALF_W-1:0];
      end
      default: store_data = wdata;
    endcase
  end

endmodule

// File: rtl/kamacore_lsu.sv
// Load/store unit: one request at a time, single-cycle memory op, valid/ready response.
module kamacore_lsu
  import kamacore_pkg::*;
#(
  parameter int unsigned MEM_ADDR_WIDTH = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [2:0]                req_funct3,
  input  logic [CPU_WIDTH-1:0]      req_addr,
  input  logic [CPU_WIDTH-1:0]      req_wdata,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [CPU_WIDTH-1:0]      resp_rdata,
  output logic                      resp_err,
  output logic [MEM_ADDR_WIDTH-1:0] mem_a,
  output logic                      mem_we,
  output logic [CPU_WIDTH-1:0]      mem_di,
  input  logic [CPU_WIDTH-1:0]      mem_spo
);

  lsu_state_t           state;
  logic                 we_q;
  logic [2:0]           funct3_q;
  logic [1:0]           addr_lo_q;
  logic [CPU_WIDTH-1:0] wdata_q;
  logic [CPU_WIDTH-1:0] load_data;
  logic [CPU_WIDTH-1:0] store_data;
  logic                 req_ok;

  // Address bits above the memory window alias and are deliberately dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[CPU_WIDTH-1:MEM_ADDR_WIDTH+2];

  assign req_ok = lsu_req_ok(req_we, req_funct3, req_addr[1:0]);

  kamacore_lsu_align u_align (
    .funct3     (funct3_q),
    .addr_lo    (addr_lo_q),
    .word       (mem_spo),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  // Write data follows the async read port within the STORE cycle.
  assign mem_di = (state == STORE) ? store_data : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_a      <= '0;
      mem_we     <= 1'b0;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      addr_lo_q  <= '0;
      wdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            funct3_q  <= req_funct3;
            addr_lo_q <= req_addr[1:0];
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (!req_ok) begin
              resp_rdata <= '0;
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              mem_a <= req_addr[MEM_ADDR_WIDTH+1:2];
              if (req_we) begin
                mem_we <= 1'b1;
                state  <= STORE;
              end else begin
                state  <= LOAD;
              end
            end
          end
        end
        LOAD: begin
          resp_rdata <= load_data;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        STORE: begin
          mem_we     <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/kamacore_lsu.md
Name: kamacore_lsu

Overview:
Load/store unit between the execute stage and the data port (a/we/di/spo) of the core's asynchronous-read memory. It accepts one RISC-V load or store per request and converts the byte address to a word address. Sub-word loads are extracted and sign- or zero-extended. Sub-word stores are done as a single-cycle read-modify-write. Results go back to writeback over a valid/ready response channel.

Parameters:
MEM_ADDR_WIDTH, 10, word-address width of the attached memory (1024 words).

Ports:
clk  input  1  core clock
rst  input  1  asynchronous active-high reset
req_valid  input  1  execute has a memory op
req_ready  output  1  LSU can accept a request (high only in IDLE)
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RISC-V width/sign code
req_addr  input  CPU_WIDTH  byte address
req_wdata  input  CPU_WIDTH  store data, LSB-aligned
resp_valid  output  1  response available
resp_ready  input  1  writeback consumes response
resp_rdata  output  CPU_WIDTH  load result (0 for stores and errors)
resp_err  output  1  misaligned or illegal funct3
mem_a  output  MEM_ADDR_WIDTH  memory word address
mem_we  output  1  memory write enable
mem_di  output  CPU_WIDTH  memory write data
mem_spo  input  CPU_WIDTH  memory async read data at mem_a

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_a=0, mem_di=0. All internal holding registers are 0.
- Request capture:
  - Handshake is req_valid && req_ready in IDLE.
  - On handshake, register we, funct3, addr and wdata.
  - Word address is addr[MEM_ADDR_WIDTH+1:2]. Upper address bits are ignored, so out-of-range addresses alias/wrap.
- Error check (done at capture):
  - Loads: funct3 in {0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU} is legal.
  - Stores: funct3 in {0 SB, 1 SH, 2 SW} is legal.
  - Halfword with addr[0]=1 is misaligned. Word with addr[1:0]!=0 is misaligned.
  - Any illegal or misaligned request goes IDLE -> RESP with resp_err=1, resp_rdata=0, and no memory access.
- States:
  - IDLE: accepts a request. A legal load goes to LOAD, a legal store to STORE.
  - LOAD (1 cycle): mem_a = held word address.
    - Select the byte lane by addr[1:0] and the half lane by addr[1].
    - Sign-extend for LB/LH, zero-extend for LBU/LHU.
    - Register the result into resp_rdata, then go to RESP.
  - STORE (1 cycle): mem_a = held word address, mem_we=1.
    - mem_di = mem_spo with the selected lane(s) replaced by wdata[7:0] or wdata[15:0]. SW writes wdata unmodified.
    - The write commits at the clock edge ending this state. Then go to RESP with resp_rdata=0, resp_err=0.
  - RESP: resp_valid=1. resp_rdata and resp_err are held stable until resp_ready, then go to IDLE.
- Latency:
  - Request accepted at edge T, op performed in cycle T+1, resp_valid from T+2.
  - Peak throughput is one request per 3 cycles. No request is accepted in RESP.
- Memory interface: mem_we is high in STORE only, for exactly one cycle per legal store. mem_a holds its last value outside LOAD/STORE.
- Reset mid-operation: async reset forces IDLE and drops mem_we immediately.
  - A store whose STORE cycle is cut by rst before the edge does not write.
  - A pending response is discarded.

Decomposition:
- kamacore_pkg holds:
  - CPU_WIDTH and ADDR_WIDTH.
  - Typedef lsu_state_t {IDLE, LOAD, STORE, RESP}.
  - funct3 constants F3_B=3'd0, F3_H=3'd1, F3_W=3'd2, F3_BU=3'd4, F3_HU=3'd5.
- One combinational sub-module, kamacore_lsu_align, does load extraction/extension and store lane merge from (funct3, addr[1:0], word, wdata).

Test Plan:
- Preload word 4 = 0x8040_20F1, issue three loads:
  - LB 0x13 -> resp_rdata 0xFFFF_FF80, err 0.
  - LBU 0x13 -> 0x0000_0080.
  - LH 0x12 -> 0xFFFF_8040.
  - resp_valid rises 2 cycles after accept.
- Word 4 = 0x1122_3344, SB addr 0x11 wdata 0xFFFF_FFAB -> word 4 = 0x1122_AB44, mem_we high exactly 1 cycle, resp_err 0.
- Misaligned and illegal requests:
  - LW 0x06 -> resp_err=1, resp_rdata=0, mem_we never asserted, memory unchanged.
  - SH 0x03 -> same.
  - Load funct3=3 -> same.
- Backpressure: hold resp_ready=0 for 3 cycles -> resp_valid/rdata/err stable, req_ready=0 throughout. Accept resumes the cycle after the handshake.
- Reset during the STORE cycle (rst asserted before the edge) -> word unchanged, mem_we 0 immediately, req_ready=1, resp_valid=0.
- Back-to-back SW 0x20 wdata 0xDEAD_BEEF then LW 0x20 with resp_ready=1 -> LW returns 0xDEAD_BEEF, second accept 3 cycles after first.
